// File: rtl/nf10_decap_if.sv
// rtl/nf10_decap_if.sv - AXI4-Stream bundle used on both sides of nf10_decap
//
// Purpose: groups one AXI4-Stream channel (tdata/tstrb/tuser/tvalid/tready/tlast).
// Parameters: DATA_W (tdata width), USER_W (tuser width).
// Modports:
//   master - drives tdata, tstrb, tuser, tvalid, tlast; samples tready
//   slave  - samples tdata, tstrb, tuser, tvalid, tlast; drives tready
`timescale 1ns/1ps
interface nf10_decap_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/nf10_decap.sv
// rtl/nf10_decap.sv - strips a fixed outer header from each AXI4-Stream packet
//
// Purpose: removes C_HDR_BYTES bytes from the front of every packet, realigns
// the payload to byte lane 0, and rewrites tuser[15:0] to the new length.
// Packets whose total size does not exceed the header are dropped as runts.
// Optional feature macro: DECAP_STATS_EN (packet / runt counters).
// Ports:
//   axi_aclk    - clock
//   axi_reset   - asynchronous active-high reset
//   s_axis      - input stream (slave modport); tuser valid on first beat
//   m_axis      - output stream (master modport); tuser held for whole packet
//   runt_drop   - one-cycle pulse per dropped runt
//   pkt_count   - packets emitted (zero unless DECAP_STATS_EN)
//   runt_count  - runts dropped (zero unless DECAP_STATS_EN)
`timescale 1ns/1ps
module nf10_decap #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_HDR_BYTES          = 14
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  nf10_decap_if.slave          s_axis,
  nf10_decap_if.master         m_axis,
  output logic                 runt_drop,
  output logic [31:0]          pkt_count,
  output logic [31:0]          runt_count
);

  localparam int S    = C_HDR_BYTES;
  localparam int R    = 32 - C_HDR_BYTES;
  localparam int SB   = S * 8;
  localparam int RB   = R * 8;
  localparam int SL   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MW   = C_M_AXIS_DATA_WIDTH;
  localparam int UW   = C_M_AXIS_TUSER_WIDTH;
  localparam int SUW  = C_S_AXIS_TUSER_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] resid_q, resid_d;
  logic [5:0]    resid_cnt_q, resid_cnt_d;
  logic [UW-1:0] tuser_q, tuser_d;
  logic          runt_drop_q, runt_drop_d;

  logic [5:0]      in_cnt;
  logic            in_short;
  logic [15:0]     in_len;
  logic [15:0]     new_len;
  logic [MW-1:0]   in_resid;
  logic [MW-1:0]   acc_data;
  logic            s_ready;
  logic            m_valid;
  logic            m_last;
  logic [MW-1:0]   m_data;
  logic [MW/8-1:0] m_strb;

  // Contiguous byte mask of n lanes starting at lane 0 (n may be 32).
  function automatic logic [31:0] ones_mask(input logic [5:0] n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < SL; i++) begin
      in_cnt = in_cnt + {5'd0, s_axis.tstrb[i]};
    end
  end

  assign in_short = (in_cnt <= 6'(S));
  assign in_len   = s_axis.tuser[15:0];
  assign new_len  = (in_len > 16'(S)) ? (in_len - 16'(S)) : 16'd0;

  // Bytes S..31 of the current beat moved down to lanes 0..R-1; upper lanes
  // come out zero, so OR-ing in the next beat's head needs no extra masking.
  assign in_resid = s_axis.tdata >> SB;
  assign acc_data = resid_q | (s_axis.tdata << RB);

  always_comb begin
    state_d     = state_q;
    resid_d     = resid_q;
    resid_cnt_d = resid_cnt_q;
    tuser_d     = tuser_q;
    runt_drop_d = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    m_strb      = '0;

    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_axis.tvalid) begin
          resid_d = in_resid;
          tuser_d = {s_axis.tuser[SUW-1:16], new_len};
          if (!s_axis.tlast) begin
            state_d     = ST_ACC;
            resid_cnt_d = 6'(R);
          end else if (in_short) begin
            runt_drop_d = 1'b1;
          end else begin
            state_d     = ST_FLUSH;
            resid_cnt_d = in_cnt - 6'(S);
          end
        end
      end

      ST_ACC: begin
        // Output is built from the live input beat, so ready passes straight
        // through and valid follows the upstream valid.
        s_ready = m_axis.tready;
        m_valid = s_axis.tvalid;
        m_data  = acc_data;
        if (s_axis.tlast && in_short) begin
          m_last = 1'b1;
          m_strb = ones_mask(6'(R) + in_cnt);
        end else begin
          m_strb = '1;
        end
        if (s_axis.tvalid && m_axis.tready) begin
          if (!s_axis.tlast) begin
            resid_d     = in_resid;
            resid_cnt_d = 6'(R);
          end else if (in_short) begin
            state_d = ST_IDLE;
          end else begin
            resid_d     = in_resid;
            resid_cnt_d = in_cnt - 6'(S);
            state_d     = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = resid_q;
        m_strb  = ones_mask(resid_cnt_q);
        if (m_axis.tready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= ST_IDLE;
      resid_q     <= '0;
      resid_cnt_q <= '0;
      tuser_q     <= '0;
      runt_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resid_q     <= resid_d;
      resid_cnt_q <= resid_cnt_d;
      tuser_q     <= tuser_d;
      runt_drop_q <= runt_drop_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = m_data;
  assign m_axis.tstrb  = m_strb;
  assign m_axis.tuser  = tuser_q;
  assign runt_drop     = runt_drop_q;

`ifdef DECAP_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] runt_count_q, runt_count_d;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    runt_count_d = runt_count_q;
    if (m_valid && m_axis.tready && m_last) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
    // Counted on the same edge that raises runt_drop so both appear together.
    if (runt_drop_d) begin
      runt_count_d = runt_count_q + 32'd1;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_count_q  <= '0;
      runt_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      runt_count_q <= runt_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign runt_count = runt_count_q;
`else
  assign pkt_count  = 32'd0;
  assign runt_count = 32'd0;
`endif

endmodule

// File: tb/tb_nf10_decap.sv
// tb/tb_nf10_decap.sv - scoreboard bench for nf10_decap
`timescale 1ns/1ps
module tb_nf10_decap;

  localparam int S = 14;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        runt_drop;
  logic [31:0] pkt_count;
  logic [31:0] runt_count;

  int    vectors    = 0;
  int    miscompares = 0;
  int    exp_runts  = 0;
  int    seen_runts = 0;
  int    exp_pkts   = 0;
  int    ready_mode = 3;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  nf10_decap_if #(.DATA_W(256), .USER_W(128)) s_if ();
  nf10_decap_if #(.DATA_W(256), .USER_W(128)) m_if ();

  nf10_decap #(
    .C_M_AXIS_DATA_WIDTH (256),
    .C_S_AXIS_DATA_WIDTH (256),
    .C_M_AXIS_TUSER_WIDTH(128),
    .C_S_AXIS_TUSER_WIDTH(128),
    .C_HDR_BYTES         (S)
  ) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .runt_drop (runt_drop),
    .pkt_count (pkt_count),
    .runt_count(runt_count)
  );

  function automatic logic [31:0] ones(input int n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  function automatic logic [255:0] byte_mask(input logic [31:0] strb);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) if (strb[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // 0: always ready, 1: random, 2: toggle every cycle, 3: held low
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ($urandom_range(0, 3) != 0);
        2:       m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor: every output handshake is matched against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (runt_drop) seen_runts++;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %h want no beat", m_if.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("data", m_if.tdata & byte_mask(e.strb), e.data);
          chk("tstrb", 256'(m_if.tstrb), 256'(e.strb));
          chk("tlast", 256'(m_if.tlast), 256'(e.last));
          chk("tuser", 256'(m_if.tuser), 256'(e.user));
        end
      end
    end
  end

  task automatic wait_s_hs(output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    while (t < 2000) begin
      @(negedge clk);
      if (s_if.tready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL s_handshake_timeout: got no tready want tready within 2000 cycles");
    end
  endtask

  // Reference model: payload is simply bytes S..L-1 of the packet, cut into
  // 32-byte chunks; the new length is L-S.
  task automatic send_pkt(input int len);
    byte unsigned  b[];
    logic [111:0]  up;
    logic [255:0]  d;
    int            nbeats;
    int            p;
    int            n;
    bit            ok;
    b = new[len];
    for (int k = 0; k < len; k++) b[k] = 8'($urandom());
    up = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    nbeats = (len + 31) / 32;
    if (len <= S) begin
      exp_runts++;
    end else begin
      p = len - S;
      for (int off = 0; off < p; off += 32) begin
        beat_t e;
        int    nb;
        nb = (p - off > 32) ? 32 : p - off;
        e.data = '0;
        for (int k = 0; k < nb; k++) e.data[8*k +: 8] = b[S + off + k];
        e.strb = ones(nb);
        e.last = (off + 32 >= p);
        e.user = {up, 16'(p)};
        exp_q.push_back(e);
      end
      exp_pkts++;
    end
    for (int i = 0; i < nbeats; i++) begin
      n = (len - 32 * i > 32) ? 32 : len - 32 * i;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
      for (int k = 0; k < n; k++) d[8*k +: 8] = b[32*i + k];
      s_if.tdata  = d;
      s_if.tstrb  = ones(n);
      s_if.tlast  = (i == nbeats - 1);
      s_if.tuser  = (i == 0) ? {up, 16'(len)} : {$urandom(), $urandom(), $urandom(), $urandom()};
      s_if.tvalid = 1'b1;
      wait_s_hs(ok);
      if (!ok) break;
      if ($urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    bit ok;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 256'(m_if.tvalid), 256'd0);
    chk("rst_tlast", 256'(m_if.tlast), 256'd0);
    chk("rst_tdata", m_if.tdata, 256'd0);
    chk("rst_tstrb", 256'(m_if.tstrb), 256'd0);
    chk("rst_tuser", 256'(m_if.tuser), 256'd0);
    chk("rst_runt_drop", 256'(runt_drop), 256'd0);
    chk("rst_s_tready", 256'(s_if.tready), 256'd1);
    chk("rst_pkt_count", 256'(pkt_count), 256'd0);
    chk("rst_runt_count", 256'(runt_count), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed packets: 64B, 42B, runt, 64B, 20B (flush only), 96B with toggling ready
    ready_mode = 0;
    send_pkt(64);
    send_pkt(42);
    send_pkt(14);
    repeat (4) @(posedge clk);
    #1;
    chk("runt_seen", 256'(seen_runts), 256'(exp_runts));
`ifdef DECAP_STATS_EN
    chk("runt_count_1", 256'(runt_count), 256'd1);
`endif
    send_pkt(64);
    send_pkt(20);
    ready_mode = 2;
    send_pkt(96);
    ready_mode = 0;
    drain();

    // Reset while in ACC with the second beat valid and output stalled
    ready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    s_if.tdata  = {8{$urandom()}};
    s_if.tstrb  = '1;
    s_if.tlast  = 1'b0;
    s_if.tuser  = {112'd0, 16'd64};
    s_if.tvalid = 1'b1;
    wait_s_hs(ok);
    s_if.tlast = 1'b1;
    @(negedge clk);
    chk("acc_tvalid_before_rst", 256'(m_if.tvalid), 256'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 256'(m_if.tvalid), 256'd0);
    chk("async_rst_s_tready", 256'(s_if.tready), 256'd1);
    chk("async_rst_pkt_count", 256'(pkt_count), 256'd0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    exp_pkts   = 0;
    exp_runts  = 0;
    seen_runts = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    send_pkt(64);
    drain();

    // Random traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       send_pkt($urandom_range(1, 32));
        1:       send_pkt($urandom_range(33, 64));
        default: send_pkt($urandom_range(1, 200));
      endcase
    end
    ready_mode = 0;
    drain();

    chk("runts_total", 256'(seen_runts), 256'(exp_runts));
`ifdef DECAP_STATS_EN
    chk("pkt_count_total", 256'(pkt_count), 256'(exp_pkts));
    chk("runt_count_total", 256'(runt_count), 256'(exp_runts));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1);
  end

endmodule
